// File: rtl/sc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sc_pkg                                                    |
// | Purpose  : Shared types and constants for the stochastic-computing    |
// |            stream decoder (FSM state enum, default window size).     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package sc_pkg;

  // Default window length exponent: a window is 2**WIN_LOG2 accepted bits.
  localparam int c_win_log2_default = 4;

  // Decoder FSM states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } sc_state_e;

endpackage : sc_pkg
`default_nettype wire

// File: rtl/sc_ones_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sc_ones_counter                                           |
// | Purpose  : Window bit counter and ones counter for the stream        |
// |            decoder. Flags the acceptance of the last bit of a window |
// |            and presents the final ones count including that bit.     |
// | Ports    : clk, rst_n      - clock, async active-low reset           |
// |            clear           - synchronous abort, zeroes both counters |
// |            accept          - a bit is accepted this cycle            |
// |            sn_bit          - the bit being accepted                  |
// |            window_done     - this acceptance completes the window    |
// |            final_ones      - ones count including the current bit   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sc_ones_counter
  import sc_pkg::*;
#(
  parameter int WIN_LOG2 = c_win_log2_default
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic              sn_bit,
  output logic              window_done,
  output logic [WIN_LOG2:0] final_ones
);

  // bit_cnt holds the number of bits already accepted in this window, so
  // it only needs to reach 2**WIN_LOG2-1; the last bit is recognised by
  // the all-ones value and the counter then wraps back to zero.
  localparam logic [WIN_LOG2-1:0] c_last_bit = '1;
  localparam logic [WIN_LOG2-1:0] c_bit_one  = {{(WIN_LOG2-1){1'b0}}, 1'b1};

  logic [WIN_LOG2-1:0] r_bit_cnt;
  // One extra bit so that an all-ones window does not wrap.
  logic [WIN_LOG2:0]   r_ones_cnt;

  assign window_done = accept && (r_bit_cnt == c_last_bit);
  assign final_ones  = r_ones_cnt + {{WIN_LOG2{1'b0}}, sn_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_ones_cnt <= '0;
    end else if (clear || window_done) begin
      r_bit_cnt  <= '0;
      r_ones_cnt <= '0;
    end else if (accept) begin
      r_bit_cnt  <= r_bit_cnt + c_bit_one;
      r_ones_cnt <= final_ones;
    end
  end

endmodule : sc_ones_counter
`default_nettype wire

// File: rtl/sc_stream_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sc_stream_decoder                                         |
// | Purpose  : Decodes a stochastic bitstream into a probability value   |
// |            by counting ones over windows of 2**WIN_LOG2 valid bits.  |
// | Config   : SC_BIPOLAR_EN defined   -> prob_out = 2*ones - 2**WIN_LOG2|
// |                                       (two's complement)             |
// |            SC_BIPOLAR_EN undefined -> prob_out = ones (unipolar)     |
// | Ports    : clk, rst_n  - clock, async active-low reset               |
// |            sn_bit      - stochastic bit sample                       |
// |            sn_valid    - sn_bit qualifier                            |
// |            clear       - synchronous window abort (beats sn_valid)   |
// |            prob_out    - decoded value of the last completed window  |
// |            prob_valid  - one-cycle pulse when prob_out updates       |
// |            busy        - a window is partially accumulated           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int WIN_LOG2 = c_win_log2_default
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sn_bit,
  input  logic                sn_valid,
  input  logic                clear,
  output logic [WIN_LOG2+1:0] prob_out,
  output logic                prob_valid,
  output logic                busy
);

  sc_state_e           r_state;
  sc_state_e           w_next_state;
  logic                w_accept;
  logic                w_window_done;
  logic [WIN_LOG2:0]   w_final_ones;
  logic [WIN_LOG2+1:0] w_decoded;
  logic [WIN_LOG2+1:0] r_prob_out;
  logic                r_prob_valid;

  // A bit arriving together with clear is discarded.
  assign w_accept = sn_valid && !clear;

  sc_ones_counter #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_ones_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .accept      (w_accept),
    .sn_bit      (sn_bit),
    .window_done (w_window_done),
    .final_ones  (w_final_ones)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = IDLE;
    end else if (w_window_done) begin
      w_next_state = IDLE;
    end else if (w_accept) begin
      w_next_state = ACCUM;
    end
  end

  always_comb begin
    busy = (r_state == ACCUM);
  end

  // ------------------------------------------------------------- decode
`ifdef SC_BIPOLAR_EN
  // 2*ones - 2**WIN_LOG2, range -2**WIN_LOG2..+2**WIN_LOG2 in WIN_LOG2+2 bits.
  localparam logic [WIN_LOG2+1:0] c_full_scale = {2'b01, {WIN_LOG2{1'b0}}};
  assign w_decoded = {w_final_ones, 1'b0} - c_full_scale;
`else
  assign w_decoded = {1'b0, w_final_ones};
`endif

  // ------------------------------------------------------ output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prob_out   <= '0;
      r_prob_valid <= 1'b0;
    end else begin
      r_prob_valid <= w_window_done;
      if (w_window_done) begin
        r_prob_out <= w_decoded;
      end
    end
  end

  assign prob_out   = r_prob_out;
  assign prob_valid = r_prob_valid;

endmodule : sc_stream_decoder
`default_nettype wire

// File: tb/tb_sc_stream_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sc_stream_decoder                                      |
// | Purpose  : Self-checking bench for sc_stream_decoder (WIN_LOG2=4).   |
// |            A driver feeds directed and random streams into a window  |
// |            model and queues expected results; a monitor compares     |
// |            every cycle's prob_valid/prob_out against that queue.     |
// |            Honours SC_BIPOLAR_EN for the expected decode.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_sc_stream_decoder;

  localparam int WIN_LOG2 = 4;
  localparam int N        = 1 << WIN_LOG2;
  localparam int OW       = WIN_LOG2 + 2;

  typedef struct {
    logic [OW-1:0] val;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sn_bit;
  logic          sn_valid;
  logic          clear;
  logic [OW-1:0] prob_out;
  logic          prob_valid;
  logic          busy;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  logic [OW-1:0] last_out = '0;
  exp_t          sb[$];
  bit            win[$];

  sc_stream_decoder #(
    .WIN_LOG2 (WIN_LOG2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sn_bit     (sn_bit),
    .sn_valid   (sn_valid),
    .clear      (clear),
    .prob_out   (prob_out),
    .prob_valid (prob_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [OW-1:0] model_val(input int ones);
`ifdef SC_BIPOLAR_EN
    return OW'(2 * ones - N);
`else
    return OW'(ones);
`endif
  endfunction

  // One stimulus cycle: check busy from the previous edge, apply inputs,
  // and advance the window model.
  task automatic step(input bit v, input bit b, input bit c);
    int ones;
    exp_t e;
    @(negedge clk);
    chk("busy", busy, win.size() != 0);
    sn_valid = v;
    sn_bit   = b;
    clear    = c;
    if (c) begin
      win.delete();
    end else if (v) begin
      win.push_back(b);
      if (win.size() == N) begin
        ones = 0;
        foreach (win[i]) ones += win[i];
        e.val = model_val(ones);
        e.cyc = cyc + 1;
        sb.push_back(e);
        win.delete();
      end
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    sn_valid = 1'b0;
    clear    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_prob_out", prob_out, 0);
    chk("rst_prob_valid", prob_valid, 0);
    chk("rst_busy", busy, 0);
    win.delete();
    sb.delete();
    last_out = '0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Monitor: every cycle, the pulse must match the queue head exactly.
  initial begin
    bit   exp_pulse;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      exp_pulse = (sb.size() > 0) && (sb[0].cyc == cyc);
      chk("prob_valid", prob_valid, exp_pulse);
      if (exp_pulse) begin
        e = sb.pop_front();
        chk("prob_out", prob_out, e.val);
        last_out = e.val;
      end else begin
        chk("prob_out_hold", prob_out, last_out);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  initial begin
    sn_bit   = 1'b0;
    sn_valid = 1'b0;
    clear    = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("init_prob_out", prob_out, 0);
    chk("init_prob_valid", prob_valid, 0);
    chk("init_busy", busy, 0);
    @(negedge clk);
    #3 rst_n = 1'b1;

    // All ones.
    for (int i = 0; i < N; i++) step(1, 1, 0);
    step(0, 0, 0);

    // Alternating 1,0 with random gaps (sn_bit noise while invalid).
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 3)) step(0, 1'($urandom), 0);
      step(1, (i % 2) == 0, 0);
    end
    step(0, 0, 0);

    // All zeros.
    for (int i = 0; i < N; i++) step(1, 0, 0);
    step(0, 0, 0);

    // Window of ones, partial window, clear with valid, then zeros.
    for (int i = 0; i < N; i++) step(1, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    step(1, 1, 1);
    for (int i = 0; i < N; i++) step(1, 0, 0);
    step(0, 0, 0);

    // Async reset mid-window, then a window with four ones.
    for (int i = 0; i < 10; i++) step(1, 1, 0);
    async_reset();
    for (int i = 0; i < N; i++) step(1, (i % 4) == 0, 0);
    step(0, 0, 0);

    // Back-to-back windows.
    for (int i = 0; i < 2 * N; i++) step(1, i < N, 0);

    // Random traffic.
    for (int i = 0; i < 700; i++) begin
      step($urandom_range(0, 99) < 70, 1'($urandom), $urandom_range(0, 99) < 3);
      if (i == 350) async_reset();
    end

    repeat (4) step(0, 0, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sc_stream_decoder
`default_nettype wire

// File: doc/sc_stream_decoder.md
SC_STREAM_DECODER -- requirements
Module: sc_stream_decoder

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 4, giving a window length of 2^WIN_LOG2 accepted bits (legal range 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port sn_bit, input, 1, the incoming stochastic bitstream sample.
REQ-005 SHALL have port sn_valid, input, 1, qualifier; sn_bit is accepted only in cycles where sn_valid=1.
REQ-006 SHALL have port clear, input, 1, synchronous abort of the current window.
REQ-007 SHALL have port prob_out, output, WIN_LOG2+2, the decoded value of the last completed window.
REQ-008 SHALL have port prob_valid, output, 1, a one-cycle pulse when prob_out updates.
REQ-009 SHALL have port busy, output, 1, high while a window is partially accumulated.

Function
REQ-010 SHALL implement states IDLE and ACCUM.
REQ-011 In IDLE, a cycle with sn_valid=1 SHALL move to ACCUM, with that bit counted as bit 1 of the window.
REQ-012 In ACCUM, each sn_valid=1 cycle SHALL increment bit_cnt and SHALL add sn_bit to ones_cnt.
REQ-013 ones_cnt SHALL be WIN_LOG2+1 bits wide, so an all-ones window (2^WIN_LOG2) is representable without wrap.
REQ-014 On acceptance of bit number 2^WIN_LOG2, the final count (including that bit) SHALL be registered into prob_out on the same edge, and prob_valid SHALL be 1 for exactly the following cycle.
REQ-015 Latency SHALL be exactly 1 clock from the last accepted bit's edge to prob_valid high.
REQ-016 After window completion, the FSM SHALL go to IDLE with counters zeroed; a valid bit on the next cycle starts a new window with no bit lost.
REQ-017 Cycles with sn_valid=0 SHALL hold all counters and state; gaps of any length are legal.
REQ-018 clear=1 SHALL zero the counters, go to IDLE, suppress prob_valid and leave prob_out unchanged.
REQ-019 clear SHALL take priority over sn_valid in the same cycle, and the bit in that cycle SHALL be discarded.
REQ-020 busy SHALL equal (state==ACCUM).
REQ-021 In unipolar mode, prob_out SHALL equal ones_cnt zero-extended to WIN_LOG2+2 bits.

Reset
REQ-022 rst_n=0 SHALL immediately force the following, regardless of clk: state=IDLE, bit_cnt=0, ones_cnt=0, prob_out=0, prob_valid=0, busy=0.
REQ-023 Reset asserted mid-window SHALL discard the partial window, and no prob_valid SHALL follow deassertion.
REQ-024 The first bit accepted after rst_n rises SHALL be bit 1 of a new window.

Configuration
REQ-025 Macro SC_BIPOLAR_EN SHALL select the decode mode.
REQ-026 With SC_BIPOLAR_EN defined, prob_out SHALL be the two's-complement value 2*ones_cnt - 2^WIN_LOG2, with range -2^WIN_LOG2..+2^WIN_LOG2.
REQ-027 Without SC_BIPOLAR_EN, prob_out SHALL be the unipolar count of REQ-021, and the bipolar arithmetic SHALL not be synthesized.
REQ-028 Mode SHALL affect only the value registered into prob_out; timing and handshake SHALL be identical in both modes.

Structure
REQ-029 Package sc_pkg SHALL hold the state enum (IDLE, ACCUM) and the WIN_LOG2 default constant.
REQ-030 Sub-module sc_ones_counter SHALL contain bit_cnt/ones_cnt, with window-done output and clear input; the FSM and output register SHALL reside in sc_stream_decoder.

Verification (WIN_LOG2=4)
REQ-031 16 consecutive valid ones -> prob_valid pulse 1 cycle after the 16th bit, prob_out=16 (unipolar) / +16 (bipolar).
REQ-032 Alternating 1,0 for 16 valid bits with sn_valid=0 gaps of 0-3 cycles -> prob_out=8 / 0; busy low only after completion.
REQ-033 16 valid zeros -> prob_out=0 / -16 (6'b110000).
REQ-034 Window of 16 ones, then clear asserted with sn_valid=1 after 5 more ones, then 16 zeros -> first result 16, no pulse at clear, next result 0, prob_out held at 16 in between.
REQ-035 rst_n pulsed low (not on a clk edge) after 10 valid bits -> all outputs 0 immediately; the next 16 bits of four ones -> prob_out=4 / -8.
REQ-036 Back-to-back windows with sn_valid=1 every cycle for 32 cycles, all ones then all zeros -> two pulses 16 cycles apart, values 16 then 0, no bit dropped.
